// File: rtl/bcd_convert_sched.sv
// Shared round-robin, bit-serial double-dabble binary-to-BCD converter for NUM_REQ requesters.
// Optional build macro BCD_BLANK_EN: leading zero digits (except digit 0) are replaced by 4'hF.
module bcd_convert_sched #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned BIN_W   = 13,
    parameter int unsigned DIGITS  = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*BIN_W-1:0]     bin_in,
    output logic [NUM_REQ-1:0]           ack,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(NUM_REQ)-1:0]   done_id,
    output logic [4*DIGITS-1:0]          bcd_out
);

    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);
    localparam int unsigned BCD_W = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    rr_q, rr_d;
    logic [ID_W-1:0]    grant_q, grant_d;
    logic [ID_W-1:0]    done_id_q, done_id_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]   dig_q, dig_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    logic [BIN_W-1:0]   bin_arr [NUM_REQ];
    logic [BCD_W-1:0]   dig_adj;
    logic [BCD_W-1:0]   dig_fmt;
    logic               found;
    logic [ID_W-1:0]    pick;
    logic [ID_W-1:0]    scan;

    // Split the packed request values into one slot per requester.
    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            bin_arr[i] = bin_in[i*BIN_W +: BIN_W];
        end
    end

    // Round-robin search starting at rr_q, wrapping at NUM_REQ.
    always_comb begin
        found = 1'b0;
        pick  = rr_q;
        scan  = rr_q;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && req[scan]) begin
                found = 1'b1;
                pick  = scan;
            end
            scan = (scan == ID_W'(NUM_REQ - 1)) ? '0 : scan + 1'b1;
        end
    end

    // Add-3 correction on every digit, taken from the pre-shift values.
    always_comb begin
        dig_adj = dig_q;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (dig_q[4*d +: 4] >= 4'd5) begin
                dig_adj[4*d +: 4] = dig_q[4*d +: 4] + 4'd3;
            end
        end
    end

    // Result formatting: optional leading-zero blanking, digit 0 always shown.
    always_comb begin
        dig_fmt = dig_q;
`ifdef BCD_BLANK_EN
        begin : blank
            logic lead;
            lead = 1'b1;
            for (int d = int'(DIGITS) - 1; d >= 1; d--) begin
                if (lead && (dig_q[4*d +: 4] == 4'd0)) begin
                    dig_fmt[4*d +: 4] = 4'hF;
                end else begin
                    lead = 1'b0;
                end
            end
        end
`endif
    end

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        grant_d   = grant_q;
        bin_d     = bin_q;
        dig_d     = dig_q;
        cnt_d     = cnt_q;
        ack_d     = '0;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        bcd_d     = bcd_q;

        unique case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = pick;
                    bin_d   = bin_arr[pick];
                    dig_d   = '0;
                    cnt_d   = CNT_W'(BIN_W);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                {dig_d, bin_d} = {dig_adj, bin_q} << 1;
                cnt_d          = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bcd_d     = dig_fmt;
                done_id_d = grant_q;
                ack_d     = NUM_REQ'(1) << grant_q;
                done_d    = 1'b1;
                rr_d      = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            rr_q      <= '0;
            grant_q   <= '0;
            bin_q     <= '0;
            dig_q     <= '0;
            cnt_q     <= '0;
            ack_q     <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_id_q <= '0;
            bcd_q     <= '0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            grant_q   <= grant_d;
            bin_q     <= bin_d;
            dig_q     <= dig_d;
            cnt_q     <= cnt_d;
            ack_q     <= ack_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            done_id_q <= done_id_d;
            bcd_q     <= bcd_d;
        end
    end

    assign ack     = ack_q;
    assign done    = done_q;
    assign busy    = busy_q;
    assign done_id = done_id_q;
    assign bcd_out = bcd_q;

endmodule
